// File: rtl/pe_pkg.sv
// Shared definitions for the systolic PE: FSM encoding and width-generic
// saturation helpers used by both the MAC datapath and output quantisation.
package pe_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

  // All helpers work on a 64-bit signed carrier; callers slice the low w bits.
  function automatic logic signed [63:0] sat_hi(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int unsigned w);
    return ~sat_hi(w);
  endfunction

  function automatic logic fits_signed(input logic signed [63:0] v,
                                       input int unsigned w);
    return (v <= sat_hi(w)) && (v >= sat_lo(w));
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int unsigned w);
    if (v > sat_hi(w))      return sat_hi(w);
    else if (v < sat_lo(w)) return sat_lo(w);
    else                    return v;
  endfunction

  // Width-specific wrappers for the accumulator and data domains.
  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v,
                                                 input int unsigned awidth);
    return sat_to(v, awidth);
  endfunction

  function automatic logic signed [63:0] sat_data(input logic signed [63:0] v,
                                                  input int unsigned dwidth);
    return sat_to(v, dwidth);
  endfunction

endpackage

// File: rtl/pe_sat_mac.sv
// Saturating signed multiply-accumulate. `load` replaces the accumulator with
// the product (new tile); otherwise the product is added with clamping.
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [AWIDTH-1:0] acc,
  output logic              sat
);

  logic signed [2*DWIDTH-1:0] prod;
  logic signed [63:0]         prod_x;
  logic signed [63:0]         acc_x;
  logic signed [63:0]         sum_x;
  logic signed [63:0]         sum_sat;
  logic                       add_ovf;
  logic                       unused_hi;

  assign prod = $signed(a) * $signed(b);

  // AWIDTH <= 48 keeps the 64-bit sum free of carrier overflow.
  always_comb begin
    prod_x  = 64'(prod);
    acc_x   = 64'($signed(acc));
    sum_x   = acc_x + prod_x;
    sum_sat = sat_acc(sum_x, AWIDTH);
    add_ovf = !fits_signed(sum_x, AWIDTH);
  end

  assign unused_hi = ^{sum_sat[63:AWIDTH], prod_x[63:AWIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (load) begin
        acc <= prod_x[AWIDTH-1:0];
        sat <= 1'b0;
      end else begin
        acc <= sum_sat[AWIDTH-1:0];
        if (add_ovf) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates a
// tile in pe_sat_mac, and shifts quantised results out on a drain chain.
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 24,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              in_valid,
  input  logic              clear,
  input  logic              drain_en,
  input  logic [DWIDTH-1:0] drain_in,
  output logic [DWIDTH-1:0] out_a,
  output logic [DWIDTH-1:0] out_b,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_c,
  output logic              overflow
);

  logic [STATE_W-1:0] state, state_nxt;
  logic [AWIDTH-1:0]  acc;
  logic               mac_load;
  logic signed [63:0] acc_x;
  logic signed [63:0] q_x;
  logic [DWIDTH-1:0]  q;
  logic               unused_q;

  // A drain request in ACCUM closes the old tile, so a coincident product
  // must start the next tile rather than extend the one being drained.
  assign mac_load = clear || (state != ST_ACCUM) || drain_en;

  pe_sat_mac #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid),
    .load  (mac_load),
    .a     (in_a),
    .b     (in_b),
    .acc   (acc),
    .sat   (overflow)
  );

  always_comb begin
    acc_x = 64'($signed(acc));
    q_x   = sat_data(acc_x >>> SHIFT, DWIDTH);
  end

  assign q        = q_x[DWIDTH-1:0];
  assign unused_q = ^q_x[63:DWIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ACCUM;
      ST_ACCUM: if (drain_en) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain_en) state_nxt = in_valid ? ST_ACCUM : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // First drain cycle captures this PE's result; later cycles shift upstream data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_c <= '0;
    end else if (drain_en) begin
      if (state == ST_ACCUM)      out_c <= q;
      else if (state == ST_DRAIN) out_c <= drain_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_a     <= in_a;
      out_b     <= in_b;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: a 20-bit accumulator instance for most
// scenarios and a 16-bit one sharing the same stimulus for saturation.
module tb_systolic_pe;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_a, in_b, drain_in;
  logic       in_valid, clear, drain_en;

  logic [7:0] out_a, out_b, out_c;
  logic       out_valid, overflow;
  logic [7:0] out_a16, out_b16, out_c16;
  logic       out_valid16, overflow16;

  int checks = 0;
  int errors = 0;

  systolic_pe #(.DWIDTH(8), .AWIDTH(20), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .clear(clear), .drain_en(drain_en), .drain_in(drain_in),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_c(out_c),
    .overflow(overflow)
  );

  systolic_pe #(.DWIDTH(8), .AWIDTH(16), .SHIFT(0)) dut16 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .clear(clear), .drain_en(drain_en), .drain_in(drain_in),
    .out_a(out_a16), .out_b(out_b16), .out_valid(out_valid16), .out_c(out_c16),
    .overflow(overflow16)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    in_a = 8'd0; in_b = 8'd0; in_valid = 1'b0; clear = 1'b0;
    drain_en = 1'b0; drain_in = 8'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int n, input logic clr_first);
    for (int i = 0; i < n; i++) begin
      in_a = a; in_b = b; in_valid = 1'b1; clear = clr_first && (i == 0);
      tick();
    end
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (out_a !== 8'd0) begin errors++; $display("FAIL reset_out_a got %0h want 0", out_a); end
    checks++; if (out_b !== 8'd0) begin errors++; $display("FAIL reset_out_b got %0h want 0", out_b); end
    checks++; if (out_c !== 8'd0) begin errors++; $display("FAIL reset_out_c got %0h want 0", out_c); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forward;
    do_reset();
    in_a = 8'd5; in_b = 8'hFD; in_valid = 1'b1; clear = 1'b1;
    tick();
    idle_inputs();
    checks++; if (out_a !== 8'd5) begin errors++; $display("FAIL fwd_out_a got %0d want 5", $signed(out_a)); end
    checks++; if (out_b !== 8'hFD) begin errors++; $display("FAIL fwd_out_b got %0d want -3", $signed(out_b)); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b want 1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_valid_drop got %b want 0", out_valid); end
    checks++; if (out_a !== 8'd0) begin errors++; $display("FAIL fwd_out_a_next got %0d want 0", out_a); end
  endtask

  task automatic test_mac_drain;
    do_reset();
    feed(8'd3, 8'd4, 4, 1'b1);
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd48) begin errors++; $display("FAIL mac_acc got %0d want 48", $signed(dut.u_mac.acc)); end
    checks++; if (out_c !== 8'd0) begin errors++; $display("FAIL mac_outc_hold got %0d want 0", out_c); end
    drain_en = 1'b1;
    tick();
    checks++; if (out_c !== 8'd48) begin errors++; $display("FAIL mac_drain got %0d want 48", out_c); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mac_overflow got %b want 0", overflow); end
    drain_en = 1'b0;
    tick();
    checks++; if (out_c !== 8'd48) begin errors++; $display("FAIL mac_drain_hold got %0d want 48", out_c); end
    // PE is IDLE now: a drain request must neither move nor shift anything
    drain_en = 1'b1; drain_in = 8'h55;
    tick();
    checks++; if (out_c !== 8'd48) begin errors++; $display("FAIL idle_drain got %0h want 30", out_c); end
    drain_en = 1'b0;
    in_a = 8'd7; in_b = 8'd1; in_valid = 1'b1; clear = 1'b0;
    tick();
    idle_inputs();
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd7) begin errors++; $display("FAIL idle_fresh_tile got %0d want 7", $signed(dut.u_mac.acc)); end
  endtask

  task automatic test_quant;
    do_reset();
    feed(8'd127, 8'd127, 4, 1'b1);
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd64516) begin errors++; $display("FAIL quant_pos_acc got %0d want 64516", $signed(dut.u_mac.acc)); end
    drain_en = 1'b1;
    tick();
    checks++; if (out_c !== 8'h7F) begin errors++; $display("FAIL quant_pos got %0d want 127", $signed(out_c)); end
    drain_en = 1'b0;
    tick();
    feed(8'h80, 8'd127, 4, 1'b1);
    checks++; if ($signed(dut.u_mac.acc) !== -20'sd65024) begin errors++; $display("FAIL quant_neg_acc got %0d want -65024", $signed(dut.u_mac.acc)); end
    drain_en = 1'b1;
    tick();
    checks++; if (out_c !== 8'h80) begin errors++; $display("FAIL quant_neg got %0d want -128", $signed(out_c)); end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation;
    do_reset();
    feed(8'd127, 8'd127, 3, 1'b1);
    checks++; if ($signed(dut16.u_mac.acc) !== 16'sd32767) begin errors++; $display("FAIL sat_acc16 got %0d want 32767", $signed(dut16.u_mac.acc)); end
    checks++; if (overflow16 !== 1'b1) begin errors++; $display("FAIL sat_flag16 got %b want 1", overflow16); end
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd48387) begin errors++; $display("FAIL sat_acc20 got %0d want 48387", $signed(dut.u_mac.acc)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_flag20 got %b want 0", overflow); end
    tick();
    checks++; if (overflow16 !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", overflow16); end
    feed(8'd1, 8'd1, 1, 1'b1);
    checks++; if ($signed(dut16.u_mac.acc) !== 16'sd1) begin errors++; $display("FAIL sat_clear_acc got %0d want 1", $signed(dut16.u_mac.acc)); end
    checks++; if (overflow16 !== 1'b0) begin errors++; $display("FAIL sat_clear_flag got %b want 0", overflow16); end
  endtask

  task automatic test_drain_chain;
    do_reset();
    feed(8'd3, 8'd4, 2, 1'b1);
    drain_en = 1'b1; drain_in = 8'h11;
    tick();
    checks++; if (out_c !== 8'd24) begin errors++; $display("FAIL chain_first got %0d want 24", out_c); end
    tick();
    checks++; if (out_c !== 8'h11) begin errors++; $display("FAIL chain_11 got %0h want 11", out_c); end
    drain_in = 8'h22;
    tick();
    checks++; if (out_c !== 8'h22) begin errors++; $display("FAIL chain_22 got %0h want 22", out_c); end
    idle_inputs();
    tick();
    checks++; if (out_c !== 8'h22) begin errors++; $display("FAIL chain_hold got %0h want 22", out_c); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    feed(8'd3, 8'd4, 2, 1'b1);
    in_a = 8'd2; in_b = 8'd2; in_valid = 1'b1; drain_en = 1'b1;
    tick();
    idle_inputs();
    checks++; if (out_c !== 8'd24) begin errors++; $display("FAIL overlap_outc got %0d want 24", out_c); end
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd4) begin errors++; $display("FAIL overlap_acc got %0d want 4", $signed(dut.u_mac.acc)); end
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    feed(8'd10, 8'd10, 1, 1'b1);
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd100) begin errors++; $display("FAIL areset_pre_acc got %0d want 100", $signed(dut.u_mac.acc)); end
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1; clear = 1'b0;
    tick();
    idle_inputs();
    // now mid-tile (acc 181) with out_valid high; reset between edges
    reset = 1'b1;
    #1;
    checks++; if (out_a !== 8'd0) begin errors++; $display("FAIL areset_out_a got %0d want 0", out_a); end
    checks++; if (out_b !== 8'd0) begin errors++; $display("FAIL areset_out_b got %0d want 0", out_b); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", out_valid); end
    checks++; if (out_c !== 8'd0) begin errors++; $display("FAIL areset_out_c got %0d want 0", out_c); end
    checks++; if ($signed(dut.u_mac.acc) !== 20'sd0) begin errors++; $display("FAIL areset_acc got %0d want 0", $signed(dut.u_mac.acc)); end
    #1;
    reset = 1'b0;
    @(negedge clk);
    feed(8'd1, 8'd1, 1, 1'b0);
    drain_en = 1'b1;
    tick();
    checks++; if (out_c !== 8'd1) begin errors++; $display("FAIL areset_fresh got %0d want 1", out_c); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_mac_drain();
    test_quant();
    test_saturation();
    test_drain_chain();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: signed operand and out_c width.
REQ-002 SHALL have parameter AWIDTH, default 24: signed accumulator width; legal range is 2*DWIDTH to 48.
REQ-003 SHALL have parameter SHIFT, default 0: arithmetic right shift applied before output quantisation; legal range is 0 to AWIDTH-DWIDTH.
REQ-004 SHALL have ports in this order:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- in_a  in  DWIDTH  signed activation from the west neighbour.
- in_b  in  DWIDTH  signed weight from the north neighbour.
- in_valid  in  1  in_a/in_b pair is valid this cycle.
- clear  in  1  qualifies in_valid: this product starts a new tile.
- drain_en  in  1  drain request or drain shift enable.
- drain_in  in  DWIDTH  drain chain input from the upstream PE.
- out_a  out  DWIDTH  registered in_a, to the east neighbour.
- out_b  out  DWIDTH  registered in_b, to the south neighbour.
- out_valid  out  1  registered in_valid.
- out_c  out  DWIDTH  drain register, saturated result.
- overflow  out  1  sticky accumulator saturation flag.

Function
REQ-005 out_a, out_b and out_valid SHALL equal in_a, in_b and in_valid delayed by exactly one cycle, updated unconditionally on every cycle.
REQ-006 The product SHALL be a full-precision signed DWIDTH x DWIDTH multiply, sign-extended to AWIDTH.
REQ-007 When in_valid=1, the accumulator SHALL be updated as follows:
- acc <= product if clear=1, or if the state is IDLE or DRAIN;
- otherwise acc <= acc + product.
REQ-008 The acc addition SHALL saturate at the signed AWIDTH limits and set overflow on saturation; there SHALL be no wrap-around.
REQ-009 overflow SHALL stay at 1 until the next acc load caused by clear, IDLE or DRAIN (REQ-007), or until reset.
REQ-010 The quantised value q SHALL be acc arithmetically shifted right by SHIFT, then saturated to signed DWIDTH (maximum 2^(DWIDTH-1)-1, minimum -2^(DWIDTH-1)).
REQ-011 The FSM SHALL have states IDLE, ACCUM and DRAIN.
REQ-012 FSM transitions SHALL be:
- IDLE to ACCUM on in_valid=1;
- ACCUM to DRAIN on drain_en=1;
- DRAIN to IDLE on drain_en=0;
- DRAIN to ACCUM when drain_en=0 and in_valid=1 in the same cycle.
REQ-013 On the ACCUM-to-DRAIN edge, out_c SHALL load q of the acc value held before that edge, so out_c is valid 1 cycle after drain_en rises.
REQ-014 In the DRAIN state with drain_en=1, out_c SHALL load drain_in each cycle, giving a shift chain with 1-cycle latency per PE.
REQ-015 When drain_en and in_valid are both 1 in ACCUM, out_c SHALL capture the old tile's result and acc SHALL load the product as the first term of the next tile.
REQ-016 drain_en in IDLE SHALL cause no state change, and out_c SHALL hold its value.
REQ-017 out_c SHALL hold its value in IDLE and ACCUM.

Reset
REQ-018 Reset is asynchronous and active-high; when reset=1, the block SHALL immediately, without waiting for a clock edge, force:
- acc, out_a, out_b, out_c = 0;
- out_valid, overflow = 0;
- state = IDLE.
REQ-019 Reset asserted mid-accumulation or mid-drain SHALL discard the partial sum; the first in_valid after release SHALL start a fresh tile.

Structure
REQ-020 Shared package pe_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, ACCUM=1, DRAIN=2) and the saturation helper functions for AWIDTH and DWIDTH.
REQ-021 The saturating multiply-accumulate datapath SHALL be one sub-module, pe_sat_mac, parametrised by DWIDTH and AWIDTH, outputting acc and a sat flag.
REQ-022 The FSM, drain register and neighbour forwarding registers SHALL stay in systolic_pe.
REQ-023 The design SHALL be fully synchronous apart from the reset.

Verification
All scenarios use DWIDTH=8, AWIDTH=20, SHIFT=0 unless stated.
REQ-024 Forwarding: in_a=5, in_b=-3, in_valid=1 for one cycle -> out_a=5, out_b=-3, out_valid=1 exactly one cycle later, then out_valid=0.
REQ-025 Basic MAC and drain: 4 cycles of (3,4) with clear=1 on the first, then drain_en=1 -> out_c=48 one cycle after drain_en rises; overflow=0.
REQ-026 Quantisation: 4 cycles of (127,127), giving acc=64516 -> out_c=127. Repeat with (-128,127) -> acc=-65024 -> out_c=-128.
REQ-027 Accumulator saturation: AWIDTH=16, 3 cycles of (127,127) -> acc=32767 and overflow=1. A following clear=1 with (1,1) -> acc=1 and overflow=0.
REQ-028 Drain chain and overlap:
- In DRAIN, hold drain_en=1 with drain_in=0x11 then 0x22 -> out_c=0x11 then 0x22, each one cycle later.
- drain_en=1 together with in_valid=1 (2,2) in ACCUM -> out_c = old result, new acc = 4.
REQ-029 Asynchronous reset: assert reset between clock edges during ACCUM with acc=100 -> all outputs 0 before the next edge. After release, a single (1,1) followed by drain_en=1 -> out_c=1.
